// File: rtl/pio_out_timed_pkg.sv
// ============================================================================
//  Module   : pio_out_timed_pkg
//  Brief    : Shared register map, STATUS/CTRL bit indices and FSM states.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pio_out_timed_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_PRESCALE  = 3'd5;
    localparam logic [2:0] ADDR_STATUS    = 3'd6;
    localparam logic [2:0] ADDR_CTRL      = 3'd7;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pio_out_timed_if.sv
// ============================================================================
//  Module   : pio_out_timed_if
//  Brief    : Avalon-MM slave bus bundle for the timed PIO output block.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface pio_out_timed_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

`default_nettype wire

// File: rtl/pio_pulse_timer.sv
// ============================================================================
//  Module   : pio_pulse_timer
//  Brief    : Prescaler plus tick down-counter timing one output pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pio_pulse_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] len,
    input  wire logic [CNT_W-1:0] prescale,
    input  wire logic             busy,
    output logic                  done_pulse
);

    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] r_ticks;
    logic [CNT_W-1:0] r_presc_lat;
    logic             w_wrap;

    assign w_wrap = (r_pre == r_presc_lat);

    // A retrigger on the final tick wins: the pulse is extended, not finished.
    assign done_pulse = busy && !start && w_wrap && (r_ticks == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre       <= '0;
            r_ticks     <= '0;
            r_presc_lat <= '0;
        end else if (start) begin
            r_pre       <= '0;
            r_ticks     <= len;
            r_presc_lat <= prescale;
        end else if (busy) begin
            if (w_wrap) begin
                r_pre   <= '0;
                r_ticks <= r_ticks - CNT_W'(1);
            end else begin
                r_pre   <= r_pre + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pio_out_timed.sv
// ============================================================================
//  Module   : pio_out_timed
//  Brief    : Avalon-MM PIO output with set/clear and timed inverting pulses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pio_out_timed
    import pio_out_timed_pkg::*;
#(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    pio_out_timed_if.slave   bus,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_pmask;
    logic [CNT_W-1:0] r_pulse_len;
    logic [CNT_W-1:0] r_prescale;
    logic             r_done;
    logic             r_irq_en;
    logic             r_irq;

    logic             w_wr;
    logic             w_start;
    logic             w_busy;
    logic             w_done_pulse;
    logic [WIDTH-1:0] w_mask;
    logic             w_unused_wd;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_mask      = bus.writedata[WIDTH-1:0];
    assign w_busy      = (r_state == ST_ACTIVE);
    assign w_start     = w_wr && (bus.address == ADDR_PULSE) &&
                         (w_mask != '0) && (r_pulse_len != '0);
    assign w_unused_wd = ^bus.writedata;

    assign out_port = r_data ^ r_pmask;
    assign irq      = r_irq;

    pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (w_start),
        .len        (r_pulse_len),
        .prescale   (r_prescale),
        .busy       (w_busy),
        .done_pulse (w_done_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_data      <= RESET_VALUE;
            r_pmask     <= '0;
            r_pulse_len <= '0;
            r_prescale  <= '0;
            r_done      <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= r_done & r_irq_en;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ACTIVE;
                        r_pmask <= w_mask;
                    end
                end
                ST_ACTIVE: begin
                    if (w_start) begin
                        r_pmask <= r_pmask | w_mask;
                    end else if (w_done_pulse) begin
                        r_state <= ST_IDLE;
                        r_pmask <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Completion beats a coincident write-1-to-clear.
            if (w_done_pulse) begin
                r_done <= 1'b1;
            end else if (w_wr && (bus.address == ADDR_STATUS) &&
                         bus.writedata[STATUS_DONE_BIT]) begin
                r_done <= 1'b0;
            end

            if (w_wr) begin
                case (bus.address)
                    ADDR_DATA:      r_data      <= w_mask;
                    ADDR_SET:       r_data      <= r_data | w_mask;
                    ADDR_CLEAR:     r_data      <= r_data & ~w_mask;
                    ADDR_PULSE_LEN: r_pulse_len <= bus.writedata[CNT_W-1:0];
                    ADDR_PRESCALE:  r_prescale  <= bus.writedata[CNT_W-1:0];
                    ADDR_CTRL:      r_irq_en    <= bus.writedata[CTRL_IRQ_EN_BIT];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:      bus.readdata = 32'(r_data);
            ADDR_PULSE_LEN: bus.readdata = 32'(r_pulse_len);
            ADDR_PRESCALE:  bus.readdata = 32'(r_prescale);
            ADDR_STATUS: begin
                bus.readdata[STATUS_BUSY_BIT] = w_busy;
                bus.readdata[STATUS_DONE_BIT] = r_done;
            end
            ADDR_CTRL:      bus.readdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            default:        bus.readdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/pio_out_timed.md
PIO_OUT_TIMED -- requirements
Module: pio_out_timed

Interface
REQ-001 Parameter WIDTH, default 4: number of output bits, legal range 1..32.
REQ-002 Parameter CNT_W, default 16: width of the pulse-length and prescale registers, legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: WIDTH-bit reset value of the DATA register.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, combinational, zero read latency, unused bits 0.
REQ-011 out_port  output  WIDTH  driven output pins.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 A write is a cycle with chipselect=1 and write_n=0; it takes effect at that rising edge.
REQ-014 Register map:
- 0 DATA rw
- 1 SET wo: DATA |= wd
- 2 CLEAR wo: DATA &= ~wd
- 3 PULSE wo
- 4 PULSE_LEN rw
- 5 PRESCALE rw
- 6 STATUS: bit0 busy ro, bit1 done w1c
- 7 CTRL rw: bit0 irq_en
REQ-015 Reads of write-only addresses (1, 2, 3) shall return 0; only the low WIDTH or CNT_W bits of writedata are used.
REQ-016 out_port shall equal DATA ^ pmask while busy, and DATA while idle; it is driven from registers with no combinational path from the bus.
REQ-017 The block has two states, IDLE and ACTIVE; busy=1 exactly in ACTIVE.
REQ-018 IDLE -> ACTIVE on a PULSE write with a nonzero masked value and PULSE_LEN!=0:
- pmask is loaded with the mask.
- The tick counter is loaded with PULSE_LEN.
- The prescaler is cleared.
REQ-019 A PULSE write is ignored when PULSE_LEN=0 or when the masked value is 0.
REQ-020 The prescaler shall count 0..PRESCALE while ACTIVE; one tick occurs at wrap, i.e. every PRESCALE+1 cycles.
REQ-021 Each tick decrements the tick counter; on the tick that brings it to 0:
- ACTIVE -> IDLE.
- pmask is cleared.
- done is set.
REQ-022 Pulse timing: out_port is inverted for exactly PULSE_LEN*(PRESCALE+1) cycles, starting the cycle after the PULSE write edge.
REQ-023 A qualifying PULSE write while ACTIVE shall:
- OR the new mask into pmask.
- Reload the tick counter from PULSE_LEN.
- Clear the prescaler (retrigger).
REQ-024 DATA, SET and CLEAR writes while ACTIVE shall update DATA immediately; out_port reflects the new DATA ^ pmask the next cycle.
REQ-025 Writes to PULSE_LEN or PRESCALE while ACTIVE shall affect only the next pulse; the running count uses latched copies.
REQ-026 Writing 1 to STATUS bit1 clears done; if the clear coincides with pulse completion, done shall remain set (set wins).
REQ-027 irq shall equal done & irq_en, registered.

Reset
REQ-028 On reset assertion, asynchronously:
- DATA=RESET_VALUE.
- pmask, counters, PULSE_LEN, PRESCALE, done and irq_en = 0.
- State=IDLE.
- out_port=RESET_VALUE.
- irq=0.
REQ-029 Reset asserted mid-pulse shall abort the pulse with no done flag set.

Structure
REQ-030 The shared package shall hold the register address constants (ADDR_DATA..ADDR_CTRL), the STATUS bit indices and the state enumeration.
REQ-031 The prescaler and tick counter shall form one sub-module, pio_pulse_timer, with ports:
- start
- len
- prescale
- busy
- done_pulse

Verification
REQ-032 Reset with WIDTH=4, RESET_VALUE=4'hA -> out_port=4'hA, readdata at address 0 = 0x0000000A, irq=0.
REQ-033 Write DATA=0x3, SET 0x8, CLEAR 0x1 -> out_port goes 3, B, A on successive cycles after each write.
REQ-034 Set PULSE_LEN=3, PRESCALE=1, DATA=0, then PULSE 0x5 -> out_port=0x5 for exactly 6 cycles, then 0; STATUS=0x2 afterwards.
REQ-035 With irq_en=1, let the pulse complete, then write STATUS=0x2 -> irq rises one cycle after completion and falls after the clear; drive the clear on the completion cycle itself -> done stays 1.
REQ-036 PULSE 0x1 (LEN=4, PRESCALE=0), then PULSE 0x2 at cycle 2 -> out_port=0x3 from cycle 3 until 4 cycles after the second write.
REQ-037 Assert reset mid-pulse -> out_port=RESET_VALUE immediately, busy=0, done=0; PULSE with LEN=0 -> no change.
